fft_bin_streamer: RTL

Receiving end of the FFT core's parallel result interface. On the core's done pulse it captures the 16-bin complex output frame and streams it one bin per transfer over a valid/ready handshake. Downstream consumers are the magnitude or packetiser logic. It is the output-side counterpart of the parallel-load start interface used to drive the core.

---
 rtl/fft_bin_streamer_pkg.sv | 17 +
 rtl/fft_frame_regfile.sv | 31 +++
 rtl/fft_bin_streamer.sv | 109 ++++++++++
 3 files changed

// File: rtl/fft_bin_streamer_pkg.sv
// Shared FFT definitions: frame geometry, streamer state encoding and the
// bit-reversal index mapping used by the core and its consumers.
package fft_bin_streamer_pkg;

    localparam int N_POINTS = 16;
    localparam int IDX_W    = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

endpackage

// File: rtl/fft_frame_regfile.sv
// Capture registers for one complex FFT frame plus the combinational bin read mux.
// Capture takes effect on the edge where cap_en is high; reads are same-cycle.
module fft_frame_regfile
    import fft_bin_streamer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        cap_en,
    input  logic [WIDTH*N_POINTS-1:0]   cap_real,
    input  logic [WIDTH*N_POINTS-1:0]   cap_imag,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic [WIDTH-1:0]            rd_real,
    output logic [WIDTH-1:0]            rd_imag
);

    logic [N_POINTS-1:0][WIDTH-1:0] frame_real;
    logic [N_POINTS-1:0][WIDTH-1:0] frame_imag;

    // Data-only storage: contents are never observed before a capture.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            frame_real <= cap_real;
            frame_imag <= cap_imag;
        end
    end

    assign rd_real = frame_real[rd_idx];
    assign rd_imag = frame_imag[rd_idx];

endmodule

// File: rtl/fft_bin_streamer.sv
// Captures a 16-bin FFT result frame on fft_done and streams one bin per transfer.
// Latency: first bin valid 1 cycle after fft_done; 1 bin/cycle with out_ready high.
// Backpressure: outputs hold while out_ready=0; a done arriving mid-frame is dropped.
module fft_bin_streamer
    import fft_bin_streamer_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int N       = 16,
    parameter bit BIT_REV = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fft_done,
    input  logic [WIDTH*N-1:0]      fft_data_real,
    input  logic [WIDTH*N-1:0]      fft_data_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_real,
    output logic [WIDTH-1:0]        out_imag,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   count_q;
    logic               overrun_q;
    logic               capture;
    logic               drop;
    logic               xfer;
    logic               last_xfer;
    logic [IDX_W-1:0]   rd_idx;
    logic [WIDTH-1:0]   rd_real;
    logic [WIDTH-1:0]   rd_imag;

    assign xfer      = out_valid & out_ready;
    assign last_xfer = xfer & out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= drop;
            if (capture) begin
                count_q <= '0;
            end else if (xfer) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // A done coinciding with the final transfer chains straight into the next frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fft_done) state_d = STREAM;
            STREAM:  if (last_xfer && !fft_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                capture = fft_done;
            end
            STREAM: begin
                capture = fft_done & last_xfer;
                drop    = fft_done & ~last_xfer;
            end
            default: begin
                capture = 1'b0;
            end
        endcase
    end

    assign rd_idx = BIT_REV ? bitrev4(count_q) : count_q;

    fft_frame_regfile #(
        .WIDTH      (WIDTH)
    ) u_regfile (
        .clk        (clk),
        .cap_en     (capture),
        .cap_real   (fft_data_real),
        .cap_imag   (fft_data_imag),
        .rd_idx     (rd_idx),
        .rd_real    (rd_real),
        .rd_imag    (rd_imag)
    );

    // Idle outputs are forced to zero so reset and idle present the same quiet bus.
    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign out_index = out_valid ? rd_idx  : '0;
    assign out_real  = out_valid ? rd_real : '0;
    assign out_imag  = out_valid ? rd_imag : '0;
    assign out_last  = out_valid && (count_q == LAST_IDX);
    assign overrun   = overrun_q;

endmodule
